// File: rtl/bloom_cnt_mem_if.sv
// Lookup and command ports of the counting Bloom filter memory.
// The design side uses the slave modport, the driver side the master modport.
interface bloom_cnt_mem_if #(
    parameter int HASH_CNT   = 10,
    parameter int HASH_WIDTH = 12
);
    logic [HASH_CNT*HASH_WIDTH-1:0] hash_i;
    logic                           hash_val_i;
    logic                           match_o;
    logic                           match_val_o;
    logic                           cmd_valid_i;
    logic                           cmd_ready_o;
    logic [1:0]                     cmd_op_i;
    logic [HASH_CNT*HASH_WIDTH-1:0] cmd_hash_i;
    logic [HASH_CNT-1:0]            cmd_mask_i;
    logic                           done_o;
    logic                           sat_o;
    logic                           busy_o;

    modport slave (
        input  hash_i, hash_val_i, cmd_valid_i, cmd_op_i, cmd_hash_i, cmd_mask_i,
        output match_o, match_val_o, cmd_ready_o, done_o, sat_o, busy_o
    );

    modport master (
        output hash_i, hash_val_i, cmd_valid_i, cmd_op_i, cmd_hash_i, cmd_mask_i,
        input  match_o, match_val_o, cmd_ready_o, done_o, sat_o, busy_o
    );
endinterface

// File: rtl/bloom_cnt_mem.sv
// Counting Bloom filter: HASH_CNT counter memories with a 2-cycle lookup path and a
// read-capture-write command FSM (insert/delete/clear) that yields to lookups.
module bloom_cnt_mem #(
    parameter int HASH_CNT   = 10,
    parameter int HASH_WIDTH = 12,
    parameter int CNT_WIDTH  = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    bloom_cnt_mem_if.slave bus
);
    localparam int                   DEPTH   = 2**HASH_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [1:0]           OP_INS  = 2'b00;
    localparam logic [1:0]           OP_DEL  = 2'b01;
    localparam logic [1:0]           OP_CLR  = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_CLR} state_t;

    state_t                              r_state;
    logic [1:0]                          r_op;
    logic [HASH_CNT*HASH_WIDTH-1:0]      r_cmd_hash;
    logic [HASH_CNT-1:0]                 r_cmd_mask;
    logic [HASH_WIDTH-1:0]               r_clr_addr;
    logic                                r_clr_report;
    logic [HASH_CNT*CNT_WIDTH-1:0]       r_cap;
    logic                                r_ready;
    logic                                r_busy;
    logic                                r_done;
    logic                                r_sat;
    logic                                r_lk_v;
    logic                                r_lk_clr;
    logic                                r_match;
    logic                                r_match_val;

    logic [HASH_CNT*CNT_WIDTH-1:0]       w_rd_all;
    logic [HASH_CNT-1:0]                 w_cell_nz;
    logic [HASH_CNT-1:0]                 w_cell_max;
    logic [HASH_CNT-1:0]                 w_we;
    logic                                w_wr_go;
    logic                                w_clr;
    logic                                w_sat_any;

    assign w_clr     = (r_state == S_CLR);
    assign w_wr_go   = (r_state == S_WR) && !bus.hash_val_i;
    assign w_sat_any = (r_op == OP_INS) && |(w_cell_max & r_cmd_mask);

    genvar gi;
    generate
        for (gi = 0; gi < HASH_CNT; gi++) begin : g_mem
            logic [CNT_WIDTH-1:0]  r_mem [DEPTH];
            logic [CNT_WIDTH-1:0]  r_rd;
            logic [CNT_WIDTH-1:0]  w_cap;
            logic [CNT_WIDTH-1:0]  w_upd;
            logic [HASH_WIDTH-1:0] w_rd_addr;
            logic [HASH_WIDTH-1:0] w_wr_addr;
            logic [CNT_WIDTH-1:0]  w_wr_data;

            // Lookups own the read port; the command read is only issued when it is free.
            assign w_rd_addr = bus.hash_val_i ? bus.hash_i[gi*HASH_WIDTH +: HASH_WIDTH]
                                              : r_cmd_hash[gi*HASH_WIDTH +: HASH_WIDTH];
            assign w_wr_addr = w_clr ? r_clr_addr : r_cmd_hash[gi*HASH_WIDTH +: HASH_WIDTH];
            assign w_wr_data = w_clr ? '0 : w_upd;
            assign w_we[gi]  = w_clr || (w_wr_go && r_cmd_mask[gi]);

            assign w_cap                              = r_cap[gi*CNT_WIDTH +: CNT_WIDTH];
            assign w_rd_all[gi*CNT_WIDTH +: CNT_WIDTH] = r_rd;
            assign w_cell_nz[gi]                      = (r_rd != '0);
            assign w_cell_max[gi]                     = (w_cap == CNT_MAX);

            // A saturated counter is sticky: neither insert nor delete moves it.
            always_comb begin
                w_upd = w_cap;
                if (r_op == OP_INS) begin
                    if (w_cap != CNT_MAX) w_upd = w_cap + CNT_WIDTH'(1);
                end else if (w_cap != '0 && w_cap != CNT_MAX) begin
                    w_upd = w_cap - CNT_WIDTH'(1);
                end
            end

            always_ff @(posedge clk_i) begin
                if (w_we[gi]) r_mem[w_wr_addr] <= w_wr_data;
                r_rd <= r_mem[w_rd_addr];
            end
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= S_CLR;
            r_op         <= OP_INS;
            r_cmd_hash   <= '0;
            r_cmd_mask   <= '0;
            r_clr_addr   <= '0;
            r_clr_report <= 1'b0;
            r_cap        <= '0;
            r_ready      <= 1'b0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_sat        <= 1'b0;
            r_lk_v       <= 1'b0;
            r_lk_clr     <= 1'b0;
            r_match      <= 1'b0;
            r_match_val  <= 1'b0;
        end else begin
            r_lk_v      <= bus.hash_val_i;
            r_lk_clr    <= bus.hash_val_i && w_clr;
            r_match_val <= r_lk_v;
            r_match     <= r_lk_v && !r_lk_clr && (&w_cell_nz);
            r_done      <= 1'b0;
            r_sat       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid_i) begin
                        r_op       <= bus.cmd_op_i;
                        r_cmd_hash <= bus.cmd_hash_i;
                        r_cmd_mask <= bus.cmd_mask_i;
                        if (bus.cmd_op_i == OP_INS || bus.cmd_op_i == OP_DEL) begin
                            r_state <= S_RD;
                            r_ready <= 1'b0;
                            r_busy  <= 1'b1;
                        end else if (bus.cmd_op_i == OP_CLR) begin
                            r_state      <= S_CLR;
                            r_clr_addr   <= '0;
                            r_clr_report <= 1'b1;
                            r_ready      <= 1'b0;
                            r_busy       <= 1'b1;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                S_RD: begin
                    if (!bus.hash_val_i) r_state <= S_CAP;
                end
                S_CAP: begin
                    r_cap   <= w_rd_all;
                    r_state <= S_WR;
                end
                S_WR: begin
                    if (!bus.hash_val_i) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_sat   <= w_sat_any;
                    end
                end
                S_CLR: begin
                    if (&r_clr_addr) begin
                        r_state      <= S_IDLE;
                        r_ready      <= 1'b1;
                        r_busy       <= 1'b0;
                        r_done       <= r_clr_report;
                        r_clr_report <= 1'b0;
                    end else begin
                        r_clr_addr <= r_clr_addr + HASH_WIDTH'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.match_o     = r_match;
    assign bus.match_val_o = r_match_val;
    assign bus.cmd_ready_o = r_ready;
    assign bus.done_o      = r_done;
    assign bus.sat_o       = r_sat;
    assign bus.busy_o      = r_busy;
endmodule

// File: tb/tb_bloom_cnt_mem.sv
// Bench for bloom_cnt_mem (3 memories, 16 cells, 2-bit counters): directed scenarios with
// literal expectations plus a per-cycle comparison against a command-level filter model.
module tb_bloom_cnt_mem;
    localparam int HC = 3;
    localparam int HW = 4;
    localparam int CW = 2;
    localparam int CMAX = 3;
    localparam int M_IDLE = 0, M_RD = 1, M_CAP = 2, M_WR = 3, M_CLR = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    bloom_cnt_mem_if #(.HASH_CNT(HC), .HASH_WIDTH(HW)) bus ();

    bloom_cnt_mem #(.HASH_CNT(HC), .HASH_WIDTH(HW), .CNT_WIDTH(CW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [11:0] pack3(input int a, input int b, input int c);
        return {4'(c), 4'(b), 4'(a)};
    endfunction

    // ---------------- model: filter contents and command progress ----------------
    typedef struct {int due; int exp;} lk_t;
    lk_t        lq[$];
    int         mm [HC][16];
    int         m_state = M_CLR;
    int         m_addr = 0;
    int         m_report = 0;
    int         m_done = 0;
    int         m_sat = 0;
    int         m_op = 0;
    logic [11:0] m_hash = '0;
    logic [2:0]  m_mask = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                m_state = M_CLR; m_addr = 0; m_report = 0; m_done = 0; m_sat = 0;
                lq.delete();
                for (int k = 0; k < HC; k++) mm[k][0] = 0;
                check("rst_ready", bus.cmd_ready_o, 0);
                check("rst_busy", bus.busy_o, 1);
                check("rst_done", bus.done_o, 0);
                check("rst_sat", bus.sat_o, 0);
                check("rst_match_val", bus.match_val_o, 0);
            end else begin
                int exp_v, hit, nd, ns, a, v, next_state;
                check("ready", bus.cmd_ready_o, int'(m_state == M_IDLE));
                check("busy", bus.busy_o, int'(m_state != M_IDLE));
                check("done", bus.done_o, m_done);
                check("sat", bus.sat_o, m_sat);
                exp_v = int'(lq.size() > 0 && lq[0].due == cyc);
                check("match_val", bus.match_val_o, exp_v);
                if (exp_v != 0) begin
                    check("match", bus.match_o, lq[0].exp);
                    void'(lq.pop_front());
                end
                // A lookup sees the contents before any write made at the end of this cycle.
                if (bus.hash_val_i) begin
                    hit = (m_state == M_CLR) ? 0 : 1;
                    for (int k = 0; k < HC; k++)
                        if (mm[k][int'(bus.hash_i[k*HW +: HW])] == 0) hit = 0;
                    lq.push_back('{cyc + 2, hit});
                end
                nd = 0; ns = 0; next_state = m_state;
                case (m_state)
                    M_IDLE: if (bus.cmd_valid_i) begin
                        m_op = int'(bus.cmd_op_i); m_hash = bus.cmd_hash_i; m_mask = bus.cmd_mask_i;
                        if (m_op <= 1) next_state = M_RD;
                        else if (m_op == 2) begin next_state = M_CLR; m_addr = 0; m_report = 1; end
                        else nd = 1;
                    end
                    M_RD:  if (!bus.hash_val_i) next_state = M_CAP;
                    M_CAP: next_state = M_WR;
                    M_WR:  if (!bus.hash_val_i) begin
                        for (int k = 0; k < HC; k++) if (m_mask[k]) begin
                            a = int'(m_hash[k*HW +: HW]);
                            v = mm[k][a];
                            if (m_op == 0) begin
                                if (v == CMAX) ns = 1; else mm[k][a] = v + 1;
                            end else if (v != 0 && v != CMAX) begin
                                mm[k][a] = v - 1;
                            end
                        end
                        nd = 1; next_state = M_IDLE;
                    end
                    default: begin
                        for (int k = 0; k < HC; k++) mm[k][m_addr] = 0;
                        if (m_addr == 15) begin next_state = M_IDLE; nd = m_report; m_report = 0; end
                        else m_addr++;
                    end
                endcase
                m_state = next_state; m_done = nd; m_sat = ns;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic lookup(input int a, input int b, input int c, input int exp, input string nm);
        @(posedge clk); #1;
        bus.hash_val_i = 1'b1; bus.hash_i = pack3(a, b, c);
        @(posedge clk); #1;
        bus.hash_val_i = 1'b0;
        @(posedge clk); @(negedge clk);
        check({nm, "_val"}, bus.match_val_o, 1);
        check(nm, bus.match_o, exp);
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [11:0] h, input logic [2:0] m,
                           output int lat, output int sat_seen, output int done_cyc);
        int a, n;
        bit ok;
        lat = -1; sat_seen = 0; done_cyc = -1; n = 0;
        do begin @(negedge clk); n++; end while (!bus.cmd_ready_o && n < 100);
        if (!bus.cmd_ready_o) begin check("cmd_ready_timeout", 0, 1); return; end
        @(posedge clk); #1;
        bus.cmd_valid_i = 1'b1; bus.cmd_op_i = op; bus.cmd_hash_i = h; bus.cmd_mask_i = m;
        a = cyc;
        @(posedge clk); #1;
        bus.cmd_valid_i = 1'b0;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (bus.done_o) begin ok = 1; lat = cyc - a; sat_seen = int'(bus.sat_o); done_cyc = cyc; end
        end
        if (!ok) check("done_timeout", 0, 1);
    endtask

    task automatic count_busy(input string nm);
        int n;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.busy_o) n++; else break;
        end
        check(nm, n, 16);
        check({nm, "_ready_after"}, bus.cmd_ready_o, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, sat, dc, last, s, n_done;
        bus.hash_i = '0; bus.hash_val_i = 1'b0; bus.cmd_valid_i = 1'b0;
        bus.cmd_op_i = 2'b00; bus.cmd_hash_i = '0; bus.cmd_mask_i = '0;

        // Power-on: reset held, then the automatic 16-cycle clear without done
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        count_busy("post_reset_busy_cycles");
        lookup(5, 6, 7, 0, "empty_lookup");

        run_cmd(2'b00, pack3(1, 2, 3), 3'b111, lat, sat, dc);
        check("insert_latency", lat, 4);
        check("insert1_sat", sat, 0);
        lookup(1, 2, 3, 1, "hit_123");
        lookup(1, 2, 4, 0, "miss_124");

        // Counters go 1->2->3, the fourth insert finds them saturated
        for (int i = 2; i <= 4; i++) begin
            run_cmd(2'b00, pack3(1, 2, 3), 3'b111, lat, sat, dc);
            check($sformatf("insert%0d_sat", i), sat, int'(i == 4));
        end
        for (int i = 0; i < 3; i++) begin
            run_cmd(2'b01, pack3(1, 2, 3), 3'b111, lat, sat, dc);
            check("delete_latency", lat, 4);
        end
        lookup(1, 2, 3, 1, "sticky_after_deletes");

        run_cmd(2'b00, pack3(8, 9, 10), 3'b111, lat, sat, dc);
        run_cmd(2'b01, pack3(8, 9, 10), 3'b111, lat, sat, dc);
        lookup(8, 9, 10, 0, "deleted_8910");
        run_cmd(2'b00, pack3(8, 9, 10), 3'b010, lat, sat, dc);
        lookup(8, 9, 10, 0, "mask010_8910");
        run_cmd(2'b00, pack3(8, 9, 10), 3'b101, lat, sat, dc);
        lookup(8, 9, 10, 1, "mask101_completes_8910");
        run_cmd(2'b00, pack3(5, 6, 7), 3'b000, lat, sat, dc);
        check("mask000_latency", lat, 4);
        lookup(5, 6, 7, 0, "mask000_no_write");

        run_cmd(2'b11, pack3(0, 0, 0), 3'b111, lat, sat, dc);
        check("reserved_op_latency", lat, 1);

        // Insert under 20 back-to-back lookups: stalls in RD until the port frees
        last = -1;
        fork
            begin
                @(posedge clk); #1;
                s = cyc;
                for (int i = 0; i < 20; i++) begin
                    bus.hash_val_i = 1'b1;
                    bus.hash_i = (i % 2 != 0) ? pack3(11, 12, 13) : pack3(1, 2, 3);
                    @(posedge clk); #1;
                end
                bus.hash_val_i = 1'b0;
                last = s + 19;
            end
            run_cmd(2'b00, pack3(11, 12, 13), 3'b111, lat, sat, dc);
        join
        check("stall_done_after_lookups", dc - last, 4);
        lookup(11, 12, 13, 1, "hit_111213");

        // Clear while lookups of a present key keep running
        fork
            begin
                @(posedge clk); #1;
                for (int i = 0; i < 24; i++) begin
                    bus.hash_val_i = 1'b1; bus.hash_i = pack3(1, 2, 3);
                    @(posedge clk); #1;
                end
                bus.hash_val_i = 1'b0;
            end
            run_cmd(2'b10, pack3(0, 0, 0), 3'b000, lat, sat, dc);
        join
        check("clear_latency", lat, 17);
        lookup(1, 2, 3, 0, "after_clear_123");

        // Reset arriving during WR of an insert
        run_cmd(2'b00, pack3(4, 5, 6), 3'b111, lat, sat, dc);
        @(negedge clk);
        @(posedge clk); #1;
        bus.cmd_valid_i = 1'b1; bus.cmd_op_i = 2'b00;
        bus.cmd_hash_i = pack3(1, 2, 3); bus.cmd_mask_i = 3'b111;
        @(posedge clk); #1;
        bus.cmd_valid_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        count_busy("wr_reset_busy_cycles");
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done_o) n_done++;
        end
        check("wr_reset_no_done", n_done, 0);
        lookup(1, 2, 3, 0, "wr_reset_lookup");
        lookup(4, 5, 6, 0, "wr_reset_cleared_456");

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bloom_cnt_mem.md
BLOOM_CNT_MEM -- requirements
Module: bloom_cnt_mem

Interface
REQ-001 Parameter HASH_CNT, default 10, number of hash functions and memories; any value >= 1, odd values allowed.
REQ-002 Parameter HASH_WIDTH, default 12, address width; each memory is 2**HASH_WIDTH cells deep.
REQ-003 Parameter CNT_WIDTH, default 2, bits per cell; CNT_WIDTH=1 gives a classic bit-vector filter.
REQ-004 clk_i  in  1  clock; all logic on its rising edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-high.
REQ-006 hash_i  in  HASH_CNT*HASH_WIDTH  lookup addresses; slice k addresses memory k.
REQ-007 hash_val_i  in  1  lookup valid.
REQ-008 match_o  out  1  lookup result; qualified by match_val_o.
REQ-009 match_val_o  out  1  lookup result valid.
REQ-010 cmd_valid_i  in  1  command request.
REQ-011 cmd_ready_o  out  1  command accepted when cmd_valid_i and cmd_ready_o are both 1.
REQ-012 cmd_op_i  in  2  opcode: 00 insert, 01 delete, 10 clear, 11 reserved.
REQ-013 cmd_hash_i  in  HASH_CNT*HASH_WIDTH  command addresses.
REQ-014 cmd_mask_i  in  HASH_CNT  per-memory enable for insert/delete; clear ignores it.
REQ-015 done_o  out  1  one-cycle pulse when an accepted command completes.
REQ-016 sat_o  out  1  one-cycle pulse when an insert finds any enabled cell already at max.
REQ-017 busy_o  out  1  high whenever the FSM is not IDLE.

Function
REQ-018 Each memory SHALL behave as one read port plus one write port, with synchronous read latency 1 and no output register.
REQ-019 Lookup: hash_val_i at cycle t SHALL produce match_val_o at t+2, unconditionally.
- match_o = AND over all k of (cell_k != 0).
- match_o is forced to 0 for any lookup whose read cycle falls while the FSM is in CLR.
REQ-020 FSM states SHALL be IDLE, RD, CAP, WR and CLR.
REQ-021 cmd_ready_o SHALL be 1 only in IDLE. Each accepted command and its fields SHALL be registered at acceptance.
REQ-022 Transitions:
- IDLE->RD on insert or delete.
- IDLE->CLR on clear.
- IDLE->IDLE on opcode 11, with done_o pulsed the next cycle.
REQ-023 RD SHALL issue reads on the command addresses only in a cycle with hash_val_i=0; otherwise it stalls in RD. RD->CAP follows the issuing cycle.
REQ-024 CAP SHALL register all HASH_CNT read values. CAP->WR unconditionally.
REQ-025 WR SHALL write updated values to the masked memories only in a cycle with hash_val_i=0; otherwise it stalls in WR. WR->IDLE after the write, with done_o pulsed in the first IDLE cycle.
REQ-026 Lookups interleaved between RD and WR SHALL see the pre-update contents. The captured values SHALL NOT be re-read.
REQ-027 Insert update per cell: cnt==2**CNT_WIDTH-1 -> unchanged and sat_o pulsed together with done_o; else cnt+1.
REQ-028 Delete update per cell:
- cnt==0 -> unchanged.
- cnt==2**CNT_WIDTH-1 -> unchanged (saturation is sticky).
- otherwise cnt-1.
REQ-029 Unmasked memories SHALL never be written. A mask of all zeros completes normally with no writes.
REQ-030 CLR SHALL write 0 to address n of every memory in its n-th cycle, n=0..2**HASH_WIDTH-1. Clear writes take priority over lookups, with no stall.
REQ-031 After the last clear address, CLR->IDLE with done_o pulsed in the first IDLE cycle.
REQ-032 Best-case latency, accept cycle a: insert/delete done_o at a+4; clear done_o at a+2**HASH_WIDTH+1.

Reset
REQ-033 On rst_i:
- FSM goes to CLR with the address counter at 0.
- match_o, match_val_o, done_o and sat_o go to 0.
- cmd_ready_o goes to 0 and busy_o to 1.
- Any in-flight command is discarded.
REQ-034 The automatic post-reset clear SHALL behave as REQ-030 but SHALL NOT pulse done_o. cmd_ready_o rises in the first IDLE cycle.

Verification (HASH_CNT=3, HASH_WIDTH=4, CNT_WIDTH=2)
REQ-035 Release reset -> busy_o=1 and cmd_ready_o=0 for 16 cycles, then 0 and 1. A lookup {5,6,7} -> match_val_o=1, match_o=0, 2 cycles later. done_o stays 0 throughout.
REQ-036 Insert {1,2,3} mask 111 with no lookups -> done_o at a+4.
- Lookup {1,2,3} -> match_o=1.
- Lookup {1,2,4} -> match_o=0.
REQ-037 Insert {1,2,3} four times -> sat_o pulses only on the 4th. Three deletes of {1,2,3} -> lookup still gives match_o=1 (sticky).
REQ-038 Insert {8,9,10}, then delete {8,9,10} mask 111 -> lookup gives 0. Insert {8,9,10} mask 010 -> only memory 1 address 9 becomes 1, and lookup gives 0.
REQ-039 Hold hash_val_i=1 for 20 cycles across an insert of {11,12,13} -> FSM stalls in RD. done_o comes 4 cycles after hash_val_i drops. All 20 lookups return valid results at t+2.
REQ-040 Clear with lookups running and {1,2,3} present -> match_o=0 throughout CLR, done_o at a+17, then lookup {1,2,3} gives 0.
REQ-041 rst_i asserted while in WR -> no write occurs, auto-clear restarts, and no done_o is pulsed.
